// File: rtl/voice_allocator.sv
// Voice allocator: assigns six active-low music keys to NUM_VOICES shared tone
// voices, each with an attack/sustain/release envelope and oldest-voice stealing.
module voice_allocator #(
    parameter int unsigned NUM_VOICES    = 3,
    parameter logic [7:0]  SUSTAIN_LEVEL = 8'd200,
    parameter logic [7:0]  DECAY_STEP    = 8'd3,
    parameter logic [7:0]  RELEASE_STEP  = 8'd2
) (
    input  logic                         CLK_1Khz,
    input  logic                         reset_n,
    input  logic [4:0]                   currentState,
    input  logic [5:0]                   input_MusicKey,
    output logic [NUM_VOICES-1:0][13:0]  voiceFrequency,
    output logic [NUM_VOICES-1:0][7:0]   voiceAmplitude,
    output logic [NUM_VOICES-1:0][2:0]   voiceKey,
    output logic [7:0]                   stealCount
);
    typedef enum logic [1:0] {IDLE, ATTACK, SUSTAIN, RELEASE} voiceState_t;

    localparam logic [2:0] NO_KEY = 3'd7;
    localparam int unsigned VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    voiceState_t                 state     [NUM_VOICES];
    voiceState_t                 stateNext [NUM_VOICES];
    logic [7:0]                  age       [NUM_VOICES];
    logic [7:0]                  ageNext   [NUM_VOICES];
    logic [NUM_VOICES-1:0][7:0]  ampNext;
    logic [NUM_VOICES-1:0][2:0]  keyNext;
    logic [7:0]                  stealNext;
    logic [5:0]                  prevKey, prevKeyNext;
    logic [5:0]                  pending, pendingNext;
    logic [5:0]                  candidates;
    logic [7:0]                  keyLevel;
    logic                        playEnable;
    logic                        serviceValid, hitValid, idleValid;
    logic [2:0]                  serviceKey;
    logic [VW-1:0]               hitVoice, idleVoice, oldestVoice, targetVoice;
    logic [7:0]                  oldestAge;

    assign playEnable = (currentState == 5'd0) || (currentState == 5'd4);
    // Pad to eight entries so a 3-bit key index can never fall outside the vector.
    assign keyLevel   = {2'b11, input_MusicKey};

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
        for (int v = 0; v < NUM_VOICES; v++) begin
            stateNext[v] = state[v];
            ampNext[v]   = voiceAmplitude[v];
            keyNext[v]   = voiceKey[v];
            ageNext[v]   = age[v];
        end
        stealNext    = stealCount;
        prevKeyNext  = input_MusicKey;
        serviceValid = 1'b0;
        serviceKey   = 3'd0;
        hitValid     = 1'b0;
        hitVoice     = '0;
        idleValid    = 1'b0;
        idleVoice    = '0;
        oldestVoice  = '0;
        oldestAge    = 8'd0;

        // A key is a candidate if newly pressed or still pending, and only while held.
        candidates = (pending | prevKey) & ~input_MusicKey;
        for (int k = 5; k >= 0; k--) begin
            if (candidates[k]) begin
                serviceValid = 1'b1;
                serviceKey   = 3'(k);
            end
        end

        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (state[v] != IDLE && voiceKey[v] == serviceKey) begin
                hitValid = 1'b1;
                hitVoice = VW'(v);
            end
            if (state[v] == IDLE) begin
                idleValid = 1'b1;
                idleVoice = VW'(v);
            end
        end
        // Strict compare keeps the lowest index on equal ages.
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (age[v] > oldestAge) begin
                oldestAge   = age[v];
                oldestVoice = VW'(v);
            end
        end
        targetVoice = hitValid ? hitVoice : (idleValid ? idleVoice : oldestVoice);

        for (int v = 0; v < NUM_VOICES; v++) begin
            if (state[v] != IDLE && age[v] != 8'hFF)
                ageNext[v] = age[v] + 8'd1;
            case (state[v])
                ATTACK, SUSTAIN: begin
                    if (keyLevel[voiceKey[v]]) begin
                        stateNext[v] = RELEASE;
                    end else if (state[v] == ATTACK) begin
                        if ({1'b0, voiceAmplitude[v]} <= {1'b0, SUSTAIN_LEVEL} + {1'b0, DECAY_STEP}) begin
                            ampNext[v]   = SUSTAIN_LEVEL;
                            stateNext[v] = SUSTAIN;
                        end else begin
                            ampNext[v] = voiceAmplitude[v] - DECAY_STEP;
                        end
                    end
                end
                RELEASE: begin
                    if (voiceAmplitude[v] <= RELEASE_STEP) begin
                        ampNext[v]   = 8'd0;
                        stateNext[v] = IDLE;
                        keyNext[v]   = NO_KEY;
                    end else begin
                        ampNext[v] = voiceAmplitude[v] - RELEASE_STEP;
                    end
                end
                default: ;
            endcase
            if (serviceValid && VW'(v) == targetVoice) begin
                stateNext[v] = ATTACK;
                ampNext[v]   = 8'hFF;
                keyNext[v]   = serviceKey;
                ageNext[v]   = 8'd0;
            end
        end

        if (serviceValid && !hitValid && !idleValid && stealCount != 8'hFF)
            stealNext = stealCount + 8'd1;
        pendingNext = candidates & ~(serviceValid ? (6'b1 << serviceKey) : 6'b0);

        if (!playEnable) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                stateNext[v] = IDLE;
                ampNext[v]   = 8'd0;
                keyNext[v]   = NO_KEY;
                ageNext[v]   = 8'd0;
            end
            stealNext   = stealCount;
            pendingNext = 6'd0;
            prevKeyNext = 6'h3F;
        end
    end

    always_ff @(posedge CLK_1Khz) begin
        // NOTE: reset is sampled on the clock edge here, so it sits inside the clocked branch, not the sensitivity list.
        if (!reset_n) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                state[v]          <= IDLE;
                age[v]            <= 8'd0;
                voiceAmplitude[v] <= 8'd0;
                voiceKey[v]       <= NO_KEY;
            end
            stealCount <= 8'd0;
            pending    <= 6'd0;
            prevKey    <= 6'h3F;
        end else begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                state[v]          <= stateNext[v];
                age[v]            <= ageNext[v];
                voiceAmplitude[v] <= ampNext[v];
                voiceKey[v]       <= keyNext[v];
            end
            stealCount <= stealNext;
            pending    <= pendingNext;
            prevKey    <= prevKeyNext;
        end
    end

    always_comb begin
        for (int v = 0; v < NUM_VOICES; v++) begin
            case (voiceKey[v])
                3'd0:    voiceFrequency[v] = 14'd400;
                3'd1:    voiceFrequency[v] = 14'd1428;
                3'd2:    voiceFrequency[v] = 14'd110;
                3'd3:    voiceFrequency[v] = 14'd600;
                3'd4:    voiceFrequency[v] = 14'd1300;
                3'd5:    voiceFrequency[v] = 14'd309;
                default: voiceFrequency[v] = 14'd0;
            endcase
        end
    end
endmodule

// File: doc/voice_allocator.md
VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 Parameter NUM_VOICES, default 3: number of shared signal-generator voices.
REQ-002 Parameter SUSTAIN_LEVEL, default 8'd200: held-key amplitude floor.
REQ-003 Parameter DECAY_STEP, default 8'd3: attack-decay decrement per tick.
REQ-004 Parameter RELEASE_STEP, default 8'd2: release decrement per tick.
REQ-005 CLK_1Khz  input  1  tick clock; all state SHALL update on its rising edge.
REQ-006 reset_n  input  1  reset, synchronous, active-low.
REQ-007 currentState  input  5  system state; play is enabled only when the value is 0 or 4.
REQ-008 input_MusicKey  input  6  music keys, active-low (0 = pressed).
REQ-009 voiceFrequency  output  NUM_VOICES x 14  per-voice frequency in Hz.
REQ-010 voiceAmplitude  output  NUM_VOICES x 8  per-voice envelope amplitude.
REQ-011 voiceKey  output  NUM_VOICES x 3  key index owned by the voice; 3'd7 means idle.
REQ-012 stealCount  output  8  saturating count of voice steals.

Function
REQ-013 Press event for key k SHALL be defined as input_MusicKey[k]==0 with previous sampled value 1; previous-value register SHALL reset/gate to all 1s.
REQ-014 Press events SHALL set pending[k]; pending[k] SHALL clear when key k is serviced or read released (1) before service.
REQ-015 Exactly one pending key, the lowest index, SHALL be serviced per tick; the remaining keys SHALL stay pending for later ticks.
REQ-016 Service priority: (a) a voice already owning k is retriggered; (b) else the lowest-index IDLE voice; (c) else the voice with the largest age, with ties going to the lowest index, is stolen and stealCount increments, saturating at 255.
REQ-017 A serviced voice SHALL, on the same edge, load voiceKey=k, voiceAmplitude=255, age=0, and state ATTACK.
REQ-018 Per-voice states SHALL be IDLE, ATTACK, SUSTAIN, and RELEASE.
REQ-019 ATTACK: amplitude -= DECAY_STEP per tick, clamped to SUSTAIN_LEVEL; on reaching SUSTAIN_LEVEL the voice enters SUSTAIN.
REQ-020 SUSTAIN: amplitude SHALL hold.
REQ-021 ATTACK or SUSTAIN with owned key read 1: the voice enters RELEASE on that edge.
REQ-022 RELEASE: amplitude -= RELEASE_STEP, saturating at 0; on reaching 0 the voice enters IDLE and voiceKey=7.
REQ-023 RELEASE with owned key pressed again: handled as a press event under REQ-013..REQ-016, so the voice is retriggered via REQ-016(a).
REQ-024 Per-voice age: 8-bit counter, incremented each tick while not IDLE, saturating at 255, cleared on allocation.
REQ-025 voiceFrequency SHALL be a combinational table lookup on voiceKey: keys 0..5 map to 400, 1428, 110, 600, 1300, 309; 7 maps to 0.
REQ-026 Amplitude arithmetic SHALL be 8-bit with explicit saturation, with no wrap below 0.
REQ-027 Latency: a press sampled at edge N with an available voice and no lower pending key SHALL produce amplitude 255 at the output after edge N.
REQ-028 Gate: when currentState is not 0 or 4, on each edge all voices SHALL go IDLE with amplitude 0 and key 7, pending SHALL clear, previous keys SHALL be set to 1, and stealCount SHALL hold.
REQ-029 A key held across the gate re-enable SHALL produce a press event on the first enabled tick.

Reset
REQ-030 With reset_n==0 at an edge: all voices IDLE, voiceAmplitude=0, voiceKey=7, voiceFrequency=0, age=0, pending=0, previous keys=all 1s, stealCount=0.
REQ-031 Reset SHALL override the gate and any in-progress allocation or envelope.

Verification
REQ-032 Reset, then press key 2 and hold -> voice0: key 2, freq 110, amp 255; then 252, 249, ... reaching 200 at tick 19 and holding.
REQ-033 Press keys 0, 1, 3 on the same tick -> keys 0, 1, 3 allocated to voices 0, 1, 2 on three consecutive ticks; stealCount=0.
REQ-034 All 3 voices busy (keys 0, 1, 3, key 0 oldest), press key 5 -> voice0 becomes key 5, amp 255, freq 309; stealCount=1.
REQ-035 Hold key 4 to sustain, release -> RELEASE; amp 198, 196, ... 0 over 100 ticks, then voiceKey=7, freq 0.
REQ-036 Key 1 held and sounding, currentState=2 for 3 ticks, then 0 -> all voices idle during gate; key 1 retriggers to 255 on the first enabled tick.
REQ-037 reset_n=0 mid-RELEASE with stealCount=5 -> after that edge, all outputs match REQ-030.
